// File: rtl/cplx_result_pkg.sv
// Shared types and defaults for the complex-unit result queue.
//   cplx_result_t : payload carried through the delay pipe and queue
//   CPLX_LATENCY_DEF / CPLX_DEPTH_DEF : default pipe depth and queue size
package cplx_result_pkg;

  localparam int SIZE_DATA         = 32;
  localparam int EXECUTION_FLAGS   = 6;
  localparam int SIZE_PHYSICAL_LOG = 7;

  localparam int CPLX_LATENCY_DEF  = 3;
  localparam int CPLX_DEPTH_DEF    = 4;

  // Flags travel opaque; SYSCALL / mispredict bits are only named for readers.
  localparam logic [EXECUTION_FLAGS-1:0] FLAG_SYSCALL = 6'b000110;

  typedef struct packed {
    logic [2*SIZE_DATA-1:0]       result;
    logic [EXECUTION_FLAGS-1:0]   flags;
    logic [SIZE_PHYSICAL_LOG-1:0] tag;
  } cplx_result_t;

endpackage

// File: rtl/cplx_result_fifo.sv
// Generic DEPTH-entry circular FIFO of cplx_result_t with flush.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : clears pointers and count at the next edge
//   push, push_data : enqueue (ignored when full unless popping same cycle)
//   pop             : dequeue head (ignored when empty)
//   head, empty     : current head entry, queue empty
//   count           : occupancy, clog2(DEPTH)+1 bits
module cplx_result_fifo
  import cplx_result_pkg::*;
#(
  parameter int DEPTH = CPLX_DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  cplx_result_t push_data,
  input  logic         pop,
  output cplx_result_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cplx_result_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // At full a push is only safe when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cplx_result_queue.sv
// Complex-ALU result delay pipe followed by an in-order writeback queue.
// Issue credit (ready_o) counts queued plus in-flight ops so a pipe exit
// always finds queue space; the pipe itself never stalls.
//   clk, reset                       : clock, synchronous active-high reset
//   valid_i, result_i, flags_i, tag_i: op from issue side
//   flush_i                          : discard all in-flight and queued ops
//   ready_o                          : issue credit
//   wb_valid_o, wb_ready_i           : writeback handshake
//   wb_result_o/wb_flags_o/wb_tag_o  : head payload (zero when not valid)
//   overflow_o                       : sticky, valid_i seen with ready_o low
// Optional macro CPLX_RESULT_BYPASS_EN: an exiting op skips the empty queue
// when writeback is ready, saving one cycle.
module cplx_result_queue
  import cplx_result_pkg::*;
#(
  parameter int LATENCY = CPLX_LATENCY_DEF,
  parameter int DEPTH   = CPLX_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  input  logic [2*SIZE_DATA-1:0]       result_i,
  input  logic [EXECUTION_FLAGS-1:0]   flags_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] tag_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [2*SIZE_DATA-1:0]       wb_result_o,
  output logic [EXECUTION_FLAGS-1:0]   wb_flags_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] wb_tag_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(DEPTH + LATENCY + 1);

  cplx_result_t        pipe_q [LATENCY];
  logic [LATENCY-1:0]  vld_pipe;
  logic [CW-1:0]       fifo_count;
  logic [OW-1:0]       pipe_cnt, occ;
  logic                accept, exit_vld, fifo_empty, push, pop;
  cplx_result_t        in_data, exit_data, fifo_head, wb_data;

  assign in_data   = '{result: result_i, flags: flags_i, tag: tag_i};
  assign exit_vld  = vld_pipe[LATENCY-1];
  assign exit_data = pipe_q[LATENCY-1];

  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < LATENCY; i++) pipe_cnt = pipe_cnt + OW'(vld_pipe[i]);
  end

  assign occ     = OW'(fifo_count) + pipe_cnt;
  assign ready_o = (occ < OW'(DEPTH));
  assign accept  = valid_i && ready_o && !flush_i;

  // Valid shift register: cleared by reset or flush, otherwise always advances.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Payload rides alongside without reset.
  always_ff @(posedge clk) begin
    pipe_q[0] <= in_data;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  // A flush-cycle valid_i is discarded outright, so it does not count as overflow.
  always_ff @(posedge clk) begin
    if (reset)                                  overflow_o <= 1'b0;
    else if (valid_i && !ready_o && !flush_i)   overflow_o <= 1'b1;
  end

`ifdef CPLX_RESULT_BYPASS_EN
  logic bypass;
  assign bypass     = fifo_empty && exit_vld && wb_ready_i;
  assign push       = exit_vld && !bypass;
  assign wb_valid_o = !fifo_empty || bypass;
  assign wb_data    = fifo_empty ? exit_data : fifo_head;
`else
  assign push       = exit_vld;
  assign wb_valid_o = !fifo_empty;
  assign wb_data    = fifo_head;
`endif

  assign pop = !fifo_empty && wb_ready_i;

  assign wb_result_o = wb_valid_o ? wb_data.result : '0;
  assign wb_flags_o  = wb_valid_o ? wb_data.flags  : '0;
  assign wb_tag_o    = wb_valid_o ? wb_data.tag    : '0;

  cplx_result_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_i),
    .push      (push),
    .push_data (exit_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_cplx_result_queue.sv
// Directed bench for cplx_result_queue (LATENCY=3, DEPTH=4).
module tb_cplx_result_queue;
  import cplx_result_pkg::*;

`ifdef CPLX_RESULT_BYPASS_EN
  localparam int LAT_OUT = 3;
`else
  localparam int LAT_OUT = 4;
`endif

  logic                         clk = 1'b0;
  logic                         reset, valid_i, flush_i, wb_ready_i;
  logic [2*SIZE_DATA-1:0]       result_i;
  logic [EXECUTION_FLAGS-1:0]   flags_i;
  logic [SIZE_PHYSICAL_LOG-1:0] tag_i;
  logic                         ready_o, wb_valid_o, overflow_o;
  logic [2*SIZE_DATA-1:0]       wb_result_o;
  logic [EXECUTION_FLAGS-1:0]   wb_flags_o;
  logic [SIZE_PHYSICAL_LOG-1:0] wb_tag_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cplx_result_queue #(.LATENCY(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .result_i(result_i),
    .flags_i(flags_i), .tag_i(tag_i), .flush_i(flush_i), .ready_o(ready_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
    .wb_flags_o(wb_flags_o), .wb_tag_o(wb_tag_o), .overflow_o(overflow_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
    result_i = '0; flags_i = '0; tag_i = '0;
    step(); step();
    reset = 1'b0;
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_ready",    64'(ready_o),    64'd1);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_wb_tag",   64'(wb_tag_o),   64'd0);
    check("rst_wb_result", wb_result_o,    64'd0);

    // Single op, tag 5, result 6: visible exactly one cycle.
    wb_ready_i = 1'b1;
    valid_i = 1'b1; result_i = 64'h6; tag_i = 7'd5;
    step();
    valid_i = 1'b0; result_i = '0; tag_i = '0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("lat_valid_%0d", k), 64'(wb_valid_o), 64'(k == LAT_OUT - 1));
      if (k == LAT_OUT - 1) begin
        check("lat_tag",    64'(wb_tag_o), 64'd5);
        check("lat_result", wb_result_o,   64'h6);
      end
      step();
    end

    // SYSCALL flags pass through; payload held while wb_ready_i low.
    wb_ready_i = 1'b0;
    valid_i = 1'b1; flags_i = 6'b000110; tag_i = 7'd9;
    step();
    valid_i = 1'b0; flags_i = '0; tag_i = '0;
    step(); step(); step();
    check("sys_valid",  64'(wb_valid_o), 64'd1);
    check("sys_flags",  64'(wb_flags_o), 64'b000110);
    check("sys_result", wb_result_o,     64'd0);
    check("sys_tag",    64'(wb_tag_o),   64'd9);
    step();
    check("hold_tag",   64'(wb_tag_o),   64'd9);
    check("hold_flags", 64'(wb_flags_o), 64'b000110);
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    check("sys_popped",      64'(wb_valid_o), 64'd0);
    check("sys_flags_zero",  64'(wb_flags_o), 64'd0);

    // Credit exhaustion: 4 accepts, 5th valid_i overflows.
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; tag_i = 7'(i);
      check($sformatf("cred_ready_%0d", i), 64'(ready_o), 64'(i < 4));
      step();
    end
    valid_i = 1'b0; tag_i = '0;
    check("overflow_set", 64'(overflow_o), 64'd1);
    step(); step(); step();
    check("full_head0",  64'(wb_tag_o), 64'd0);
    check("full_ready",  64'(ready_o),  64'd0);
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    check("pop0_head1",  64'(wb_tag_o), 64'd1);
    check("pop0_ready",  64'(ready_o),  64'd1);

    // Push from pipe exit coinciding with a pop keeps count and order.
    valid_i = 1'b1; tag_i = 7'd4;
    step();
    valid_i = 1'b0; tag_i = '0;
    check("pp_ready_lo", 64'(ready_o), 64'd0);
    step(); step();
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    check("pp_head2",    64'(wb_tag_o), 64'd2);
    check("pp_ready",    64'(ready_o),  64'd1);
    wb_ready_i = 1'b1;
    for (int t = 2; t <= 4; t++) begin
      check($sformatf("drain_tag_%0d", t), 64'(wb_tag_o), 64'(t));
      step();
    end
    check("drain_empty", 64'(wb_valid_o), 64'd0);
    wb_ready_i = 1'b0;

    // Flush with 2 queued and 2 in the pipe, plus a valid_i that cycle.
    valid_i = 1'b1; tag_i = 7'd10; step();
    tag_i = 7'd11; step();
    valid_i = 1'b0; tag_i = '0;
    step(); step(); step();
    valid_i = 1'b1; tag_i = 7'd12; step();
    tag_i = 7'd13; step();
    check("pre_flush_head",  64'(wb_tag_o), 64'd10);
    check("pre_flush_ready", 64'(ready_o),  64'd0);
    flush_i = 1'b1; tag_i = 7'd14;
    step();
    flush_i = 1'b0; valid_i = 1'b0; tag_i = '0;
    check("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    check("flush_ready",    64'(ready_o),    64'd1);
    wb_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("flush_quiet_%0d", k), 64'(wb_valid_o), 64'd0);
      step();
    end

    // Reset mid-flight drops the op and clears overflow.
    valid_i = 1'b1; tag_i = 7'd20; step();
    valid_i = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    check("rst2_overflow", 64'(overflow_o), 64'd0);
    check("rst2_ready",    64'(ready_o),    64'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst2_quiet_%0d", k), 64'(wb_valid_o), 64'd0);
      step();
    end

    // Queue still usable after reset.
    valid_i = 1'b1; tag_i = 7'd21; result_i = 64'hDEAD_BEEF_0000_0001;
    step();
    valid_i = 1'b0; tag_i = '0; result_i = '0;
    for (int k = 0; k < LAT_OUT - 1; k++) step();
    check("post_valid",  64'(wb_valid_o), 64'd1);
    check("post_tag",    64'(wb_tag_o),   64'd21);
    check("post_result", wb_result_o,     64'hDEAD_BEEF_0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
